// File: rtl/pxs_ball_overlay.sv
// pxs_ball_overlay: paints a bouncing square ball into a 26-bit VGA pixel
// stream with one cycle of latency. The ball moves once per frame on the
// first blank line and reflects off the visible-area edges.
module pxs_ball_overlay #(
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned BALL_SIZE = 8,
   parameter int unsigned SPEED     = 1,
   parameter int unsigned INIT_X    = 320,
   parameter int unsigned INIT_Y    = 240,
   parameter logic [2:0]  BALL_RGB  = 3'b111
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [25:0] VGAStr_i,
   output logic [25:0] VGAStr_o,
   output logic [9:0]  ball_x,
   output logic [9:0]  ball_y,
   output logic        bounce_x,
   output logic        bounce_y
);

   typedef enum logic {DIR_POS = 1'b0, DIR_NEG = 1'b1} dir_e;

   localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
   localparam logic [10:0] V_LIM = 11'(V_ACTIVE);
   localparam logic [10:0] BS    = 11'(BALL_SIZE);
   localparam logic [10:0] SP    = 11'(SPEED);

   logic [25:0] vga_q, vga_d;
   logic [9:0]  x_q, x_d, y_q, y_d;
   dir_e        dx_q, dx_d, dy_q, dy_d;
   logic        bx_q, bx_d, by_q, by_d;

   logic [10:0] xc11, yc11, x11, y11;
   logic        act, hit, tick;
   logic [2:0]  rgb_d;

   assign xc11 = {1'b0, VGAStr_i[22:13]};
   assign yc11 = {1'b0, VGAStr_i[12:3]};
   assign act  = VGAStr_i[0];
   assign x11  = {1'b0, x_q};
   assign y11  = {1'b0, y_q};

   // Ball hit test and frame-tick detection on the incoming word
   always_comb begin
      hit  = act && (xc11 >= x11) && (xc11 < x11 + BS) &&
                    (yc11 >= y11) && (yc11 < y11 + BS);
      tick = !act && (xc11 == '0) && (yc11 == V_LIM);
      if (!act)     rgb_d = '0;
      else if (hit) rgb_d = BALL_RGB;
      else          rgb_d = VGAStr_i[25:23];
      vga_d = {rgb_d, VGAStr_i[22:0]};
   end

   // Per-axis motion with wall reflection, only on an enabled frame tick
   always_comb begin
      x_d  = x_q;
      y_d  = y_q;
      dx_d = dx_q;
      dy_d = dy_q;
      bx_d = 1'b0;
      by_d = 1'b0;
      if (tick && enable) begin
         if (dx_q == DIR_POS) begin
            if (x11 + BS + SP > H_LIM) begin
               x_d  = 10'(H_LIM - BS);
               dx_d = DIR_NEG;
               bx_d = 1'b1;
            end else begin
               x_d = 10'(x11 + SP);
            end
         end else begin
            if (x11 < SP) begin
               x_d  = '0;
               dx_d = DIR_POS;
               bx_d = 1'b1;
            end else begin
               x_d = 10'(x11 - SP);
            end
         end
         if (dy_q == DIR_POS) begin
            if (y11 + BS + SP > V_LIM) begin
               y_d  = 10'(V_LIM - BS);
               dy_d = DIR_NEG;
               by_d = 1'b1;
            end else begin
               y_d = 10'(y11 + SP);
            end
         end else begin
            if (y11 < SP) begin
               y_d  = '0;
               dy_d = DIR_POS;
               by_d = 1'b1;
            end else begin
               y_d = 10'(y11 - SP);
            end
         end
      end
   end

   // Registered stream output, ball state and bounce pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         vga_q <= '0;
         x_q   <= 10'(INIT_X);
         y_q   <= 10'(INIT_Y);
         dx_q  <= DIR_POS;
         dy_q  <= DIR_POS;
         bx_q  <= 1'b0;
         by_q  <= 1'b0;
      end else begin
         vga_q <= vga_d;
         x_q   <= x_d;
         y_q   <= y_d;
         dx_q  <= dx_d;
         dy_q  <= dy_d;
         bx_q  <= bx_d;
         by_q  <= by_d;
      end
   end

   assign VGAStr_o = vga_q;
   assign ball_x   = x_q;
   assign ball_y   = y_q;
   assign bounce_x = bx_q;
   assign bounce_y = by_q;

endmodule

// File: tb/tb_pxs_ball_overlay.sv
// Bench for pxs_ball_overlay: three instances with different start positions
// and speeds, checked against a frame-level reference model of the ball.
module tb_pxs_ball_overlay;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b1;
   logic [25:0] vin = '0;
   logic [25:0] vo [3];
   logic [9:0]  bxo [3];
   logic [9:0]  byo [3];
   logic        pbx [3];
   logic        pby [3];

   int total = 0;
   int bad = 0;

   int P_IX [3] = '{320, 631, 632};
   int P_IY [3] = '{240, 240, 472};
   int P_SP [3] = '{1, 2, 8};

   int          mx [3];
   int          my [3];
   int          mdx [3];
   int          mdy [3];
   logic [25:0] eo [3];
   bit          ebx [3];
   bit          eby [3];

   always #5 clk = ~clk;

   pxs_ball_overlay #(.INIT_X(320), .INIT_Y(240), .SPEED(1)) u0 (
      .clk(clk), .reset(reset), .enable(enable), .VGAStr_i(vin), .VGAStr_o(vo[0]),
      .ball_x(bxo[0]), .ball_y(byo[0]), .bounce_x(pbx[0]), .bounce_y(pby[0]));
   pxs_ball_overlay #(.INIT_X(631), .INIT_Y(240), .SPEED(2)) u1 (
      .clk(clk), .reset(reset), .enable(enable), .VGAStr_i(vin), .VGAStr_o(vo[1]),
      .ball_x(bxo[1]), .ball_y(byo[1]), .bounce_x(pbx[1]), .bounce_y(pby[1]));
   pxs_ball_overlay #(.INIT_X(632), .INIT_Y(472), .SPEED(8)) u2 (
      .clk(clk), .reset(reset), .enable(enable), .VGAStr_i(vin), .VGAStr_o(vo[2]),
      .ball_x(bxo[2]), .ball_y(byo[2]), .bounce_x(pbx[2]), .bounce_y(pby[2]));

   function automatic logic [25:0] mk(input logic [2:0] rgb, input int xc, input int yc,
                                      input logic hs, input logic vs, input logic act);
      return {rgb, 10'(xc), 10'(yc), hs, vs, act};
   endfunction

   function automatic logic [25:0] tick_word();
      return mk(3'b000, 0, 480, 1'b0, 1'b0, 1'b0);
   endfunction

   // One axis of motion: move by s, reflect at 0 and at lim-8
   function automatic void axis(input int p, input int d, input int s, input int lim,
                                output int np, output int nd, output bit b);
      np = p; nd = d; b = 1'b0;
      if (d > 0) begin
         if (p + 8 + s > lim) begin np = lim - 8; nd = -1; b = 1'b1; end
         else np = p + s;
      end else begin
         if (p < s) begin np = 0; nd = 1; b = 1'b1; end
         else np = p - s;
      end
   endfunction

   // Present one word, advance the model, then wait until just after the edge
   task automatic step(input logic [25:0] w);
      int  xc, yc;
      bit  act, tick, hit;
      @(negedge clk);
      vin  = w;
      xc   = int'(w[22:13]);
      yc   = int'(w[12:3]);
      act  = w[0];
      tick = !act && xc == 0 && yc == 480;
      for (int i = 0; i < 3; i++) begin
         if (reset) begin
            eo[i] = '0; mx[i] = P_IX[i]; my[i] = P_IY[i];
            mdx[i] = 1; mdy[i] = 1; ebx[i] = 1'b0; eby[i] = 1'b0;
         end else begin
            hit = act && xc >= mx[i] && xc < mx[i] + 8 && yc >= my[i] && yc < my[i] + 8;
            eo[i] = {act ? (hit ? 3'b111 : w[25:23]) : 3'b000, w[22:0]};
            ebx[i] = 1'b0; eby[i] = 1'b0;
            if (tick && enable) begin
               axis(mx[i], mdx[i], P_SP[i], 640, mx[i], mdx[i], ebx[i]);
               axis(my[i], mdy[i], P_SP[i], 480, my[i], mdy[i], eby[i]);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int k = 0; k < 3; k++) step(mk(3'($urandom), 320, 240, 1'b1, 1'b0, 1'b1));
      reset = 1'b1;
      step(mk(3'b101, 321, 241, 1'b0, 1'b1, 1'b1));
      step(mk(3'b011, 50, 60, 1'b1, 1'b1, 1'b1));
      total++;
      if ({vo[0], bxo[0], byo[0], pbx[0], pby[0]} !== {26'd0, 10'd320, 10'd240, 2'b00}) begin
         bad++;
         $display("FAIL reset: got out=%h x=%0d y=%0d bx=%b by=%b, want out=0 x=320 y=240 pulses=0",
                  vo[0], bxo[0], byo[0], pbx[0], pby[0]);
      end
      total++;
      if ({bxo[1], byo[1], bxo[2], byo[2]} !== {10'd631, 10'd240, 10'd632, 10'd472}) begin
         bad++;
         $display("FAIL reset_init: got u1=(%0d,%0d) u2=(%0d,%0d), want (631,240) (632,472)",
                  bxo[1], byo[1], bxo[2], byo[2]);
      end
      reset = 1'b0;
   endtask

   task automatic test_draw();
      logic [25:0] w;
      logic [2:0]  rgbs [4] = '{3'b111, 3'b000, 3'b111, 3'b000};
      int          xs [4] = '{320, 328, 327, 327};
      int          ys [4] = '{240, 240, 247, 248};
      for (int k = 0; k < 4; k++) begin
         w = mk(3'b000, xs[k], ys[k], 1'b1, 1'b0, 1'b1);
         step(w);
         total++;
         if (vo[0] !== {rgbs[k], w[22:0]}) begin
            bad++;
            $display("FAIL draw[%0d]: got %h, want %h", k, vo[0], {rgbs[k], w[22:0]});
         end
      end
      w = mk(3'b010, 10, 10, 1'b0, 1'b1, 1'b1);
      step(w);
      total++;
      if (vo[0] !== w) begin
         bad++;
         $display("FAIL draw_pass: got %h, want %h", vo[0], w);
      end
   endtask

   task automatic test_blank();
      logic [25:0] w;
      w = mk(3'b111, 100, 240, 1'b1, 1'b1, 1'b0);
      step(w);
      total++;
      if (vo[0] !== {3'b000, w[22:0]}) begin
         bad++;
         $display("FAIL blank: got %h, want %h", vo[0], {3'b000, w[22:0]});
      end
   endtask

   task automatic test_motion();
      logic [25:0] nt [3];
      nt[0] = mk(3'b000, 0, 480, 1'b0, 1'b0, 1'b1);
      nt[1] = mk(3'b000, 1, 480, 1'b0, 1'b0, 1'b0);
      nt[2] = mk(3'b000, 0, 479, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step(nt[k]);
         total++;
         if ({bxo[0], byo[0], pbx[0], pby[0]} !== {10'd320, 10'd240, 2'b00}) begin
            bad++;
            $display("FAIL no_tick[%0d]: got (%0d,%0d), want (320,240)", k, bxo[0], byo[0]);
         end
      end
      step(tick_word());
      total++;
      if ({bxo[0], byo[0], pbx[0], pby[0]} !== {10'd321, 10'd241, 2'b00}) begin
         bad++;
         $display("FAIL motion: got (%0d,%0d) b=%b%b, want (321,241) b=00",
                  bxo[0], byo[0], pbx[0], pby[0]);
      end
   endtask

   task automatic test_wall();
      reset = 1'b1;
      step('0);
      reset = 1'b0;
      step(tick_word());
      total++;
      if ({bxo[1], byo[1], pbx[1], pby[1]} !== {10'd632, 10'd242, 2'b10}) begin
         bad++;
         $display("FAIL wall_hit: got (%0d,%0d) b=%b%b, want (632,242) b=10",
                  bxo[1], byo[1], pbx[1], pby[1]);
      end
      step(mk(3'b000, 5, 5, 1'b0, 1'b0, 1'b1));
      total++;
      if ({bxo[1], pbx[1], pby[1]} !== {10'd632, 2'b00}) begin
         bad++;
         $display("FAIL wall_pulse: got x=%0d b=%b%b, want x=632 b=00", bxo[1], pbx[1], pby[1]);
      end
      step(tick_word());
      total++;
      if ({bxo[1], pbx[1]} !== {10'd630, 1'b0}) begin
         bad++;
         $display("FAIL wall_back: got x=%0d bx=%b, want x=630 bx=0", bxo[1], pbx[1]);
      end
   endtask

   task automatic test_corner_pause();
      reset = 1'b1;
      step('0);
      reset = 1'b0;
      step(tick_word());
      total++;
      if ({bxo[2], byo[2], pbx[2], pby[2]} !== {10'd632, 10'd472, 2'b11}) begin
         bad++;
         $display("FAIL corner: got (%0d,%0d) b=%b%b, want (632,472) b=11",
                  bxo[2], byo[2], pbx[2], pby[2]);
      end
      step(mk(3'b000, 0, 0, 1'b0, 1'b0, 1'b1));
      total++;
      if ({pbx[2], pby[2]} !== 2'b00) begin
         bad++;
         $display("FAIL corner_pulse: got b=%b%b, want 00", pbx[2], pby[2]);
      end
      enable = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step(tick_word());
         total++;
         if ({bxo[2], byo[2], bxo[0], byo[0], pbx[2], pby[2]} !==
             {10'd632, 10'd472, 10'd321, 10'd241, 2'b00}) begin
            bad++;
            $display("FAIL pause[%0d]: got u2=(%0d,%0d) u0=(%0d,%0d), want (632,472) (321,241)",
                     k, bxo[2], byo[2], bxo[0], byo[0]);
         end
      end
      enable = 1'b1;
      step(tick_word());
      total++;
      if ({bxo[2], byo[2], pbx[2], pby[2]} !== {10'd624, 10'd464, 2'b00}) begin
         bad++;
         $display("FAIL resume: got (%0d,%0d) b=%b%b, want (624,464) b=00",
                  bxo[2], byo[2], pbx[2], pby[2]);
      end
   endtask

   task automatic test_random();
      logic [25:0] w;
      int          k, xc, yc;
      for (int n = 0; n < 3000; n++) begin
         reset  = ($urandom_range(0, 399) == 0);
         enable = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 3) == 0) begin
            w = tick_word();
         end else begin
            k  = int'($urandom_range(0, 2));
            xc = mx[k] + int'($urandom_range(0, 11)) - 2;
            yc = my[k] + int'($urandom_range(0, 11)) - 2;
            if ($urandom_range(0, 4) == 0) begin
               xc = int'($urandom_range(0, 1023));
               yc = int'($urandom_range(0, 1023));
            end
            if (xc < 0) xc = 0;
            if (yc < 0) yc = 0;
            w = mk(3'($urandom), xc, yc, 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 4) != 0));
         end
         step(w);
         for (int i = 0; i < 3; i++) begin
            total++;
            if ({vo[i], bxo[i], byo[i], pbx[i], pby[i]} !==
                {eo[i], 10'(mx[i]), 10'(my[i]), ebx[i], eby[i]}) begin
               bad++;
               $display("FAIL random[%0d] u%0d: got out=%h pos=(%0d,%0d) b=%b%b, want out=%h pos=(%0d,%0d) b=%b%b",
                        n, i, vo[i], bxo[i], byo[i], pbx[i], pby[i],
                        eo[i], mx[i], my[i], ebx[i], eby[i]);
            end
         end
      end
      reset = 1'b0;
      enable = 1'b1;
   endtask

   initial begin
      step('0);
      test_reset();
      test_draw();
      test_blank();
      test_motion();
      test_wall();
      test_corner_pause();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1);
   end

endmodule
